median_sort_ctrl: RTL and testbench

Sequencing controller that time-shares one external 8-bit magnitude comparator (`COMPARATOR_8`, `Z = (A > B)`) to find the median, minimum and maximum of a block of N samples. It buffers N input bytes and sorts them in place with an odd-even transposition schedule, issuing one comparison per clock. It then presents the results on a valid/ready output port. It sits between the sample source and the comparator datapath and owns the comparator exclusively.

---
 rtl/median_sort_ctrl_if.sv | 28 ++
 rtl/median_sort_ctrl.sv | 117 +++++++++++
 tb/tb_median_sort_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/median_sort_ctrl_if.sv
// Sample input, shared comparator and result handshake bundle for median_sort_ctrl.
// The controller connects through the master modport; the source, comparator and consumer use the slave modport.
interface median_sort_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_z;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_median;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic             busy;

  modport master (
    input  in_valid, in_data, cmp_z, out_ready,
    output in_ready, cmp_a, cmp_b, out_valid, out_median, out_min, out_max, busy
  );

  modport slave (
    output in_valid, in_data, cmp_z, out_ready,
    input  in_ready, cmp_a, cmp_b, out_valid, out_median, out_min, out_max, busy
  );
endinterface

// File: rtl/median_sort_ctrl.sv
// Buffers N samples and sorts them in place with odd-even transposition on one shared comparator.
// States: IDLE waits for sample 0, LOAD takes the rest, SORT does one compare per cycle, DONE holds the results.
module median_sort_ctrl #(
  parameter int WIDTH = 8,
  parameter int N     = 5
) (
  input  logic               clk,
  input  logic               reset,
  median_sort_ctrl_if.master bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST      = CW'(N - 1);
  localparam logic [CW-1:0] EVEN_LAST = CW'(N - 3);
  localparam logic [CW-1:0] ODD_LAST  = CW'(N - 2);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sbuf [N];
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    pass;
  logic [CW-1:0]    idx;
  logic [CW-1:0]    idx_p1;
  logic             pass_end;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;
  logic [WIDTH-1:0] med_r;
  logic [WIDTH-1:0] min_r;
  logic [WIDTH-1:0] max_r;

  assign idx_p1   = idx + 1'b1;
  assign pass_end = pass[0] ? (idx == ODD_LAST) : (idx == EVEN_LAST);

  // The comparator answers in the same cycle, so the operands come straight from the buffer.
  assign bus.cmp_a      = (state == SORT) ? sbuf[idx]    : '0;
  assign bus.cmp_b      = (state == SORT) ? sbuf[idx_p1] : '0;
  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.busy       = busy_r;
  assign bus.out_median = med_r;
  assign bus.out_min    = min_r;
  assign bus.out_max    = max_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      pass        <= '0;
      idx         <= '0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      med_r       <= '0;
      min_r       <= '0;
      max_r       <= '0;
      for (int i = 0; i < N; i++) sbuf[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (in_ready_r && bus.in_valid) begin
            sbuf[0] <= bus.in_data;
            cnt     <= CW'(1);
            state   <= LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            sbuf[cnt] <= bus.in_data;
            if (cnt == LAST) begin
              state      <= SORT;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b1;
              pass       <= '0;
              idx        <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        SORT: begin
          if (bus.cmp_z) begin
            sbuf[idx]    <= sbuf[idx_p1];
            sbuf[idx_p1] <= sbuf[idx];
          end
          if (pass_end) begin
            if (pass == LAST) begin
              state <= DONE;
            end else begin
              pass <= pass + 1'b1;
              idx  <= pass[0] ? CW'(0) : CW'(1);
            end
          end else begin
            idx <= idx + CW'(2);
          end
        end
        DONE: begin
          // First DONE cycle captures the settled buffer; results then hold until accepted.
          if (!out_valid_r) begin
            out_valid_r <= 1'b1;
            med_r       <= sbuf[N/2];
            min_r       <= sbuf[0];
            max_r       <= sbuf[N-1];
          end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b1;
            cnt         <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_sort_ctrl.sv
// Directed blocks with hand-computed results; a negedge monitor pops a scoreboard on each accepted result.
module tb_median_sort_ctrl;
  logic clk = 1'b0;
  logic reset;

  median_sort_ctrl_if #(.WIDTH(8)) bus ();

  median_sort_ctrl #(.WIDTH(8), .N(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  assign bus.cmp_z = (bus.cmp_a > bus.cmp_b);

  typedef struct {
    logic [7:0] med;
    logic [7:0] mn;
    logic [7:0] mx;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   rise_cyc = 0;
  int   acc_cnt = 0;
  int   ov_cnt = 0;
  int   cmp_cnt = 0;
  int   z_cnt = 0;
  logic prev_ov = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!reset && bus.in_valid && bus.in_ready) acc_cnt++;
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (bus.cmp_a != 8'h00 || bus.cmp_b != 8'h00) cmp_cnt++;
      if (bus.cmp_z) z_cnt++;
      if (bus.out_valid) ov_cnt++;
      if (bus.out_valid && !prev_ov) rise_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_median", bus.out_median, e.med);
          chk("out_min", bus.out_min, e.mn);
          chk("out_max", bus.out_max, e.mx);
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  // Entered and left at 2 time units after a rising edge.
  task automatic send(input logic [7:0] a0, a1, a2, a3, a4, input bit gap);
    logic [7:0] d [5];
    int t;
    d[0] = a0; d[1] = a1; d[2] = a2; d[3] = a3; d[4] = a4;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      t = 0;
      while (!bus.in_ready && t < 100) begin
        @(posedge clk); #2;
        t++;
      end
      if (t >= 100) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #2;
      last_acc = cyc;
      bus.in_valid = 1'b0;
      if (gap && i < 4) begin
        @(posedge clk); #2;
      end
    end
  endtask

  task automatic push(input logic [7:0] med, mn, mx);
    exp_t e;
    e.med = med; e.mn = mn; e.mx = mx;
    sb.push_back(e);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 100) chk("result_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic clear_counts();
    ov_cnt = 0; cmp_cnt = 0; z_cnt = 0;
  endtask

  initial begin
    logic [7:0] h_med, h_min, h_max;
    int t;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_cmp_a", bus.cmp_a, 0);
    chk("rst_cmp_b", bus.cmp_b, 0);
    chk("rst_out_median", bus.out_median, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_in_ready", bus.in_ready, 1);
    @(posedge clk); #2;

    // Basic block
    clear_counts();
    send(8'h65, 8'h72, 8'h10, 8'hFF, 8'h40, 1'b0);
    push(8'h65, 8'h10, 8'hFF);
    drain();
    chk("basic_latency", rise_cyc - last_acc, 11);
    chk("basic_valid_cycles", ov_cnt, 1);
    chk("basic_cmp_cycles", cmp_cnt, 10);

    // Descending worst case
    clear_counts();
    send(8'hF0, 8'hC0, 8'h80, 8'h40, 8'h00, 1'b0);
    push(8'h80, 8'h00, 8'hF0);
    drain();
    chk("desc_latency", rise_cyc - last_acc, 11);
    chk("desc_valid_cycles", ov_cnt, 1);

    // All duplicates
    clear_counts();
    send(8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 1'b0);
    push(8'h33, 8'h33, 8'h33);
    drain();
    chk("dup_cmp_z_count", z_cnt, 0);
    chk("dup_cmp_cycles", cmp_cnt, 10);

    // Gapped input
    clear_counts();
    acc_cnt = 0;
    send(8'h05, 8'h01, 8'h04, 8'h02, 8'h03, 1'b1);
    push(8'h03, 8'h01, 8'h05);
    drain();
    chk("gap_accepted", acc_cnt, 5);
    chk("gap_latency", rise_cyc - last_acc, 11);

    // Backpressure
    clear_counts();
    bus.out_ready = 1'b0;
    send(8'h21, 8'h09, 8'h87, 8'h3C, 8'h50, 1'b0);
    push(8'h3C, 8'h09, 8'h87);
    t = 0;
    while (!bus.out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("bp_valid_timeout", 0, 1);
    h_med = bus.out_median; h_min = bus.out_min; h_max = bus.out_max;
    chk("bp_first_median", h_med, 8'h3C);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_cmp_a", bus.cmp_a, 0);
      chk("bp_stable", {bus.out_median, bus.out_min, bus.out_max}, {h_med, h_min, h_max});
    end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", bus.in_ready, 1);
    chk("bp_idle_out_valid", bus.out_valid, 0);
    chk("bp_idle_busy", bus.busy, 0);
    @(posedge clk); #2;
    send(8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 1'b0);
    push(8'h0C, 8'h0A, 8'h0E);
    drain();

    // Reset on the 4th SORT cycle
    clear_counts();
    send(8'h11, 8'h99, 8'h55, 8'h22, 8'h77, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_cmp_a", bus.cmp_a, 0);
    chk("mid_rst_out_median", bus.out_median, 0);
    chk("mid_rst_out_max", bus.out_max, 0);
    repeat (20) @(posedge clk);
    #2;
    chk("mid_rst_no_valid", ov_cnt, 0);
    send(8'h65, 8'h72, 8'h10, 8'hFF, 8'h40, 1'b0);
    push(8'h65, 8'h10, 8'hFF);
    drain();
    chk("post_rst_latency", rise_cyc - last_acc, 11);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
